branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch resolution and prediction block for the RV32i core. It evaluates all six conditional-branch conditions from raw operands and resolves the branch against a prediction made earlier in fetch. A bimodal table of 2-bit saturating counters supplies that prediction and is trained on each resolved branch. Fetch reads the prediction combinationally; execute reports resolved branches and receives a registered outcome one cycle later, including the PC offset, the mispredict flag and the redirect target.

## Interface

Parameters:
- XLEN, 32, operand, immediate and PC width
- BHT_DEPTH, 64, number of counters; power of two, at least 4
- COUNTER_INIT, 2'b01, reset value of every counter (weakly not-taken)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pc_f  input  XLEN  fetch-stage PC for prediction lookup
- pred_taken_f  output  1  combinational prediction for pc_f: counter bit 1
- res_valid  input  1  execute-stage request valid
- branch  input  1  instruction is a conditional branch
- funct_3  input  3  RISC-V branch funct3
- res_pc  input  XLEN  PC of the resolving instruction
- rs1, rs2  input  XLEN each  compare operands
- imm_in  input  XLEN  sign-extended branch offset
- pred_taken  input  1  prediction carried from fetch for this instruction
- flush  input  1  discard this cycle's request
- out_valid  output  1  registered: result below is valid
- taken  output  1  registered: branch condition true
- mispredict  output  1  registered: taken differs from pred_taken
- imm_out  output  XLEN  registered: imm_in if taken, else 4
- redirect_pc  output  XLEN  registered: res_pc+imm_in if taken, else res_pc+4
- illegal  output  1  registered: branch with funct_3 of 010 or 011
- branch_count  output  32  saturating count of resolved branches
- mispredict_count  output  32  saturating count of mispredicts

## Operation

- An accepted request is res_valid & ~flush. Requests with branch=0 also produce out_valid=1, with taken=0, mispredict=0, imm_out=4 and redirect_pc=res_pc+4. Requests with flush=1 produce nothing.
- Conditions by funct_3:
  - 000 BEQ: rs1==rs2
  - 001 BNE: rs1!=rs2
  - 100 BLT: signed rs1<rs2
  - 101 BGE: signed rs1>=rs2
  - 110 BLTU: unsigned rs1<rs2
  - 111 BGEU: unsigned rs1>=rs2
- funct_3 of 010 or 011 with branch=1 gives taken=0, illegal=1 and mispredict=0. The counter is not updated and neither count changes.
- Index is pc[log2(BHT_DEPTH)+1:2]. Fetch and resolve use the same mapping.
- Counter training, on an accepted legal branch only:
  - taken: counter+1, saturating at 3
  - not taken: counter-1, saturating at 0
  - The write takes effect at the clock edge.
- Address arithmetic is modulo 2^XLEN: redirect_pc wraps silently. rs1/rs2 are compared in full XLEN.
- Counts:
  - branch_count increments on each accepted legal branch.
  - mispredict_count increments when that branch also mispredicts.
  - Both saturate at 32'hFFFF_FFFF.

## Timing

- Resolve latency is 1 cycle: a request accepted in cycle N drives its outputs in cycle N+1. out_valid is high for exactly one cycle per accepted request. Back-to-back requests are sustained every cycle.
- pred_taken_f is purely combinational from pc_f and the current table contents.
- Read during write: when pc_f maps to the counter being trained in the same cycle, pred_taken_f returns the pre-update value. The new value is visible from the next cycle.
- Consecutive resolves to the same index each see the previous cycle's update (3 taken in a row: 01→10→11→11).
- Reset values:
  - All counters are COUNTER_INIT.
  - out_valid, taken, mispredict and illegal are 0.
  - imm_out is 4.
  - redirect_pc is 0.
  - branch_count and mispredict_count are 0.
- Reset mid-operation: rst overrides any request in the same cycle. No training occurs and out_valid=0 next cycle.
- flush with res_valid in the same cycle: no output, no training, no count change.

## Test plan

- Reset, then hold pc_f=0x100 → pred_taken_f=0. Outputs are at their reset values, counts are 0.
- BLT with rs1=0xFFFF_FFFF and rs2=1, then BLTU with the same operands (res_pc=0x200, imm_in=0x40) → BLT: taken=1, redirect_pc=0x240, imm_out=0x40. BLTU: taken=0, redirect_pc=0x204, imm_out=4.
- Three taken BEQs at res_pc=0x100 with pred_taken=0 → mispredict=1,1,0 (the third is predicted correctly once carried from fetch). Counter goes 01→10→11→11, and pred_taken_f at 0x100 becomes 1 after the first update. Final counts: branch_count=3, mispredict_count=2.
- Resolve at 0x100 while pc_f=0x100 in the same cycle → pred_taken_f shows the old value that cycle and the new value the next cycle.
- funct_3=010 with branch=1 → illegal=1, taken=0, imm_out=4, no counter change, no count change. Then res_valid=1 with flush=1 → out_valid stays 0.
- res_pc=0xFFFF_FFF0 with imm_in=0x20, taken → redirect_pc=0x0000_0010. Assert rst during a valid request → out_valid=0 next cycle and counters return to COUNTER_INIT.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch lookup, execute resolve request and registered outcome bundle
interface branch_predict_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc_f;
  logic            pred_taken_f;
  logic            res_valid;
  logic            branch;
  logic [2:0]      funct_3;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm_in;
  logic            pred_taken;
  logic            flush;
  logic            out_valid;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] imm_out;
  logic [XLEN-1:0] redirect_pc;
  logic            illegal;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;
  modport master (
    output pc_f, res_valid, branch, funct_3, res_pc, rs1, rs2, imm_in, pred_taken, flush,
    input  pred_taken_f, out_valid, taken, mispredict, imm_out, redirect_pc, illegal,
           branch_count, mispredict_count
  );
  modport slave (
    input  pc_f, res_valid, branch, funct_3, res_pc, rs1, rs2, imm_in, pred_taken, flush,
    output pred_taken_f, out_valid, taken, mispredict, imm_out, redirect_pc, illegal,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch condition resolve, bimodal 2-bit predictor and mispredict accounting
module branch_predict_unit #(
  parameter int         XLEN         = 32,
  parameter int         BHT_DEPTH    = 64,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input logic clk,
  input logic rst,
  branch_predict_unit_if.slave bus
);
  localparam int IW = $clog2(BHT_DEPTH);
  logic [BHT_DEPTH-1:0][1:0] bht_q;
  logic [IW-1:0]   f_idx, r_idx;
  logic [1:0]      ctr;
  logic            eq, lt, ltu, cond, ill_d, acc, legal, taken_d, misp_d;
  logic [XLEN-1:0] imm_d;
  logic            out_valid_q, taken_q, misp_q, ill_q;
  logic [XLEN-1:0] imm_q, redir_q;
  logic [31:0]     bcnt_q, mcnt_q;
  logic            unused_pc;
  always_comb begin
    f_idx   = bus.pc_f[IW+1:2];
    r_idx   = bus.res_pc[IW+1:2];
    ctr     = bht_q[r_idx];
    eq      = bus.rs1 == bus.rs2;
    lt      = $signed(bus.rs1) < $signed(bus.rs2);
    ltu     = bus.rs1 < bus.rs2;
    // funct_3[0] inverts the base compare: BNE/BGE/BGEU
    cond    = (bus.funct_3[2] ? (bus.funct_3[1] ? ltu : lt) : eq) ^ bus.funct_3[0];
    ill_d   = bus.branch & (bus.funct_3[2:1] == 2'b01);
    acc     = bus.res_valid & ~bus.flush;
    legal   = acc & bus.branch & ~ill_d;
    taken_d = bus.branch & ~ill_d & cond;
    misp_d  = bus.branch & ~ill_d & (taken_d ^ bus.pred_taken);
    imm_d   = taken_d ? bus.imm_in : XLEN'(4);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bht_q       <= {BHT_DEPTH{COUNTER_INIT}};
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      misp_q      <= 1'b0;
      ill_q       <= 1'b0;
      imm_q       <= XLEN'(4);
      redir_q     <= '0;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
    end else begin
      out_valid_q <= acc;
      if (acc) begin
        taken_q <= taken_d;
        misp_q  <= misp_d;
        ill_q   <= ill_d;
        imm_q   <= imm_d;
        redir_q <= bus.res_pc + imm_d;
      end
      if (legal) begin
        bht_q[r_idx] <= taken_d ? ctr + {1'b0, ctr != 2'b11} : ctr - {1'b0, ctr != 2'b00};
        bcnt_q       <= bcnt_q + {31'b0, ~&bcnt_q};
        if (misp_d) mcnt_q <= mcnt_q + {31'b0, ~&mcnt_q};
      end
    end
  end
  assign unused_pc            = ^{bus.pc_f[XLEN-1:IW+2], bus.pc_f[1:0]};
  assign bus.pred_taken_f     = bht_q[f_idx][1];
  assign bus.out_valid        = out_valid_q;
  assign bus.taken            = taken_q;
  assign bus.mispredict       = misp_q;
  assign bus.illegal          = ill_q;
  assign bus.imm_out          = imm_q;
  assign bus.redirect_pc      = redir_q;
  assign bus.branch_count     = bcnt_q;
  assign bus.mispredict_count = mcnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench with a reference predictor table and resolve model
module tb_branch_predict_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  branch_predict_unit_if #(.XLEN(32)) bus();
  branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .COUNTER_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  typedef struct packed {
    logic        tk;
    logic        mp;
    logic [31:0] imm;
    logic [31:0] rd;
    logic        il;
  } res_t;
  res_t        exp_q[$];
  res_t        e, o;
  logic [1:0]  bht_m[64];
  int unsigned bc_m, mc_m;
  logic        pend_v, pend_t, pend_m;
  logic [5:0]  pend_i;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    bc_m = 0;
    mc_m = 0;
    pend_v = 1'b0;
    exp_q.delete();
  endtask

  task automatic req(input logic br, input logic [2:0] f3, input logic [31:0] pc, a, b, imm,
                     input logic pt, input logic fl);
    logic c, il, tk;
    bus.res_valid = 1'b1; bus.branch = br; bus.funct_3 = f3; bus.res_pc = pc;
    bus.rs1 = a; bus.rs2 = b; bus.imm_in = imm; bus.pred_taken = pt; bus.flush = fl;
    case (f3)
      3'b000:  c = a == b;
      3'b001:  c = a != b;
      3'b100:  c = $signed(a) < $signed(b);
      3'b101:  c = $signed(a) >= $signed(b);
      3'b110:  c = a < b;
      3'b111:  c = a >= b;
      default: c = 1'b0;
    endcase
    il = br && (f3 == 3'b010 || f3 == 3'b011);
    tk = br && !il && c;
    if (!fl) begin
      exp_q.push_back(res_t'{tk, br && !il && (tk != pt), tk ? imm : 32'd4, pc + (tk ? imm : 32'd4), il});
      pend_v = br && !il;
      pend_i = pc[7:2];
      pend_t = tk;
      pend_m = tk != pt;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pend_v && !rst) begin
      bht_m[pend_i] = pend_t ? (bht_m[pend_i] == 2'b11 ? 2'b11 : bht_m[pend_i] + 2'b01)
                             : (bht_m[pend_i] == 2'b00 ? 2'b00 : bht_m[pend_i] - 2'b01);
      bc_m++;
      if (pend_m) mc_m++;
    end
    pend_v = 1'b0;
    bus.res_valid = 1'b0; bus.flush = 1'b0; bus.branch = 1'b0;
    o = {bus.taken, bus.mispredict, bus.imm_out, bus.redirect_pc, bus.illegal};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.pc_f = 32'h100;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_vec++;
    if (o !== res_t'{1'b0, 1'b0, 32'd4, 32'd0, 1'b0}) begin n_bad++; $display("FAIL reset_outs: got %h want %h", o, res_t'{1'b0, 1'b0, 32'd4, 32'd0, 1'b0}); end
    n_vec++;
    if ({bus.branch_count, bus.mispredict_count} !== 64'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.branch_count, bus.mispredict_count); end
    n_vec++;
    if (bus.pred_taken_f !== 1'b0) begin n_bad++; $display("FAIL reset_pred: got %b want 0", bus.pred_taken_f); end
  endtask

  task automatic test_signed_unsigned();
    req(1'b1, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0);
    step();
    e = exp_q.pop_front();
    n_vec++;
    if (!bus.out_valid || o !== e || bus.redirect_pc !== 32'h240) begin n_bad++; $display("FAIL blt: valid=%b got %h want %h", bus.out_valid, o, e); end
    req(1'b1, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b0);
    step();
    e = exp_q.pop_front();
    n_vec++;
    if (!bus.out_valid || o !== e || bus.redirect_pc !== 32'h204) begin n_bad++; $display("FAIL bltu: valid=%b got %h want %h", bus.out_valid, o, e); end
  endtask

  task automatic test_beq_train();
    logic pt;
    do_reset();
    bus.pc_f = 32'h100;
    for (int k = 0; k < 3; k++) begin
      #1;
      pt = (k == 2) ? bus.pred_taken_f : 1'b0;
      req(1'b1, 3'b000, 32'h100, 32'd7, 32'd7, 32'h10, pt, 1'b0);
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (!bus.out_valid || o !== e || bus.mispredict !== (k < 2)) begin n_bad++; $display("FAIL beq%0d: valid=%b got %h want %h", k, bus.out_valid, o, e); end
      n_vec++;
      if (bus.pred_taken_f !== bht_m[0][1] || bus.pred_taken_f !== 1'b1) begin n_bad++; $display("FAIL beq_pred%0d: got %b want %b", k, bus.pred_taken_f, bht_m[0][1]); end
    end
    n_vec++;
    if (bus.branch_count !== 32'd3 || bus.mispredict_count !== 32'd2) begin n_bad++; $display("FAIL beq_counts: got %0d/%0d want 3/2", bus.branch_count, bus.mispredict_count); end
  endtask

  task automatic test_read_during_write();
    bus.pc_f = 32'h100;
    for (int k = 0; k < 2; k++) begin
      req(1'b1, 3'b001, 32'h100, 32'd9, 32'd9, 32'h10, 1'b1, 1'b0);
      #1;
      n_vec++;
      if (bus.pred_taken_f !== bht_m[0][1]) begin n_bad++; $display("FAIL rdw_old%0d: got %b want %b", k, bus.pred_taken_f, bht_m[0][1]); end
      step();
      e = exp_q.pop_front();
      n_vec++;
      if (!bus.out_valid || o !== e) begin n_bad++; $display("FAIL rdw_res%0d: valid=%b got %h want %h", k, bus.out_valid, o, e); end
      n_vec++;
      if (bus.pred_taken_f !== bht_m[0][1] || bus.pred_taken_f !== (k == 0)) begin n_bad++; $display("FAIL rdw_new%0d: got %b want %b", k, bus.pred_taken_f, bht_m[0][1]); end
    end
  endtask

  task automatic test_illegal_flush();
    bus.pc_f = 32'h100;
    req(1'b1, 3'b010, 32'h100, 32'd3, 32'd3, 32'h40, 1'b1, 1'b0);
    step();
    e = exp_q.pop_front();
    n_vec++;
    if (!bus.out_valid || o !== e || bus.illegal !== 1'b1 || bus.imm_out !== 32'd4) begin n_bad++; $display("FAIL illegal: valid=%b got %h want %h", bus.out_valid, o, e); end
    n_vec++;
    if (bus.branch_count !== bc_m || bus.mispredict_count !== mc_m || bus.pred_taken_f !== bht_m[0][1]) begin n_bad++; $display("FAIL illegal_state: got %0d/%0d/%b want %0d/%0d/%b", bus.branch_count, bus.mispredict_count, bus.pred_taken_f, bc_m, mc_m, bht_m[0][1]); end
    req(1'b1, 3'b000, 32'h100, 32'd1, 32'd1, 32'h8, 1'b0, 1'b1);
    step();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.branch_count !== bc_m || bus.pred_taken_f !== bht_m[0][1]) begin n_bad++; $display("FAIL flush: valid=%b count=%0d want 0/%0d", bus.out_valid, bus.branch_count, bc_m); end
  endtask

  task automatic test_wrap();
    req(1'b1, 3'b111, 32'hFFFF_FFF0, 32'd5, 32'd5, 32'h20, 1'b1, 1'b0);
    step();
    e = exp_q.pop_front();
    n_vec++;
    if (!bus.out_valid || o !== e || bus.redirect_pc !== 32'h10) begin n_bad++; $display("FAIL wrap: valid=%b got %h want %h", bus.out_valid, o, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int n = 0; n < 60; n++) begin
      bus.pc_f = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 3) != 0) begin
        a = 32'($urandom_range(0, 3)) - 32'd2;
        b = 32'($urandom_range(0, 3)) - 32'd2;
        req(1'($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 7)) * 4,
            a, b, 32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
      end
      #1;
      n_vec++;
      if (bus.pred_taken_f !== bht_m[bus.pc_f[7:2]][1]) begin n_bad++; $display("FAIL b2b_pred%0d: got %b want %b", n, bus.pred_taken_f, bht_m[bus.pc_f[7:2]][1]); end
      step();
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (!bus.out_valid || o !== e) begin n_bad++; $display("FAIL b2b_res%0d: valid=%b got %h want %h", n, bus.out_valid, o, e); end
      end else begin
        n_vec++;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle%0d: valid=%b want 0", n, bus.out_valid); end
      end
    end
    n_vec++;
    if (bus.branch_count !== bc_m || bus.mispredict_count !== mc_m) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", bus.branch_count, bus.mispredict_count, bc_m, mc_m); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 3'b000, 32'h100, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0);
      step();
      void'(exp_q.pop_front());
    end
    model_reset();
    req(1'b1, 3'b000, 32'h100, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.branch_count !== 32'd0 || bus.mispredict_count !== 32'd0) begin n_bad++; $display("FAIL rst_mid: valid=%b counts=%0d/%0d want 0 0/0", bus.out_valid, bus.branch_count, bus.mispredict_count); end
    for (int i = 0; i < 64; i++) begin
      bus.pc_f = 32'(i) * 4;
      #1;
      n_vec++;
      if (bus.pred_taken_f !== 1'b0) begin n_bad++; $display("FAIL rst_ctr%0d: got %b want 0", i, bus.pred_taken_f); end
    end
  endtask

  initial begin
    bus.pc_f = 32'h100; bus.res_valid = 1'b0; bus.branch = 1'b0; bus.funct_3 = 3'b000;
    bus.res_pc = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm_in = '0; bus.pred_taken = 1'b0; bus.flush = 1'b0;
    do_reset();
    test_reset();
    test_signed_unsigned();
    test_beq_train();
    test_read_during_write();
    test_illegal_flush();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
